// File: rtl/melody_game_pkg.sv
// Shared types and constants for the melody-memory game engine.
package melody_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY_ON,
    ST_PLAY_OFF,
    ST_WAIT_KEY,
    ST_ECHO,
    ST_DONE
  } state_t;

  localparam int SILENT = 0;

  // Tone/key codes carry one extra bit so note+1 never overflows.
  function automatic int code_w(input int note_w);
    return note_w + 1;
  endfunction

endpackage

// File: rtl/melody_tick_gen.sv
// Timing tick divider: pulses every TICK_DIV clocks, restartable so a new phase starts on a full tick.
module melody_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || (cnt == CW'(TICK_DIV - 1))) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CW'(TICK_DIV - 1));

endmodule

// File: rtl/melody_game_engine.sv
// Melody-memory game core: plays a growing note prefix, then checks the player's keys note by note.
// Define GAME_LIVES_EN to end the game after LIVES misses instead of replaying forever.
module melody_game_engine
  import melody_game_pkg::*;
#(
  parameter int MAX_LEN    = 8,
  parameter int NOTE_W     = 3,
  parameter int TICK_DIV   = 500000,
  parameter int ON_TICKS   = 3,
  parameter int OFF_TICKS  = 1,
  parameter int ECHO_TICKS = 2
`ifdef GAME_LIVES_EN
  , parameter int LIVES    = 3
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MAX_LEN*NOTE_W-1:0]    seq_data,
  input  logic                         seq_load,
  input  logic                         start,
  input  logic                         key_valid,
  input  logic [NOTE_W:0]              key_code,
  output logic [NOTE_W:0]              piezo_out,
  output logic [NOTE_W:0]              led_out,
  output logic                         miss_out,
  output logic                         game_end,
  output logic                         busy,
  output logic [$clog2(MAX_LEN+1)-1:0] level
);

  localparam int CODE_W = code_w(NOTE_W);
  localparam int LVL_W  = $clog2(MAX_LEN + 1);
  localparam int TC_W   = 8;

  state_t                    state, state_n;
  logic [MAX_LEN*NOTE_W-1:0] seq_reg;
  logic                      loaded;
  logic [LVL_W-1:0]          idx, idx_n, cur_level, level_n;
  logic [TC_W-1:0]           tick_cnt;
  logic [CODE_W-1:0]         key_reg, note_code;
  logic                      match_reg, key_match, miss_n;
  logic                      tick, restart, idle_like, last_tick;
`ifdef GAME_LIVES_EN
  localparam int MISS_W = $clog2(LIVES + 1);
  logic [MISS_W-1:0]         miss_cnt, miss_cnt_n;
`endif

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign note_code = {1'b0, seq_reg[idx*NOTE_W +: NOTE_W]} + CODE_W'(1);
  assign key_match = (key_code == note_code);
  assign restart   = (state_n != state);

  melody_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    level_n   = cur_level;
    miss_n    = 1'b0;
    last_tick = 1'b0;
`ifdef GAME_LIVES_EN
    miss_cnt_n = miss_cnt;
`endif
    case (state)
      ST_PLAY_ON:  last_tick = tick && (tick_cnt == TC_W'(ON_TICKS - 1));
      ST_PLAY_OFF: last_tick = tick && (tick_cnt == TC_W'(OFF_TICKS - 1));
      ST_ECHO:     last_tick = tick && (tick_cnt == TC_W'(ECHO_TICKS - 1));
      default:     last_tick = 1'b0;
    endcase
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start && loaded) begin
          state_n = ST_PLAY_ON;
          idx_n   = '0;
          level_n = LVL_W'(1);
`ifdef GAME_LIVES_EN
          miss_cnt_n = '0;
`endif
        end
      end
      ST_PLAY_ON: if (last_tick) state_n = ST_PLAY_OFF;
      ST_PLAY_OFF: begin
        if (last_tick) begin
          if (idx == cur_level - 1'b1) begin
            state_n = ST_WAIT_KEY;
            idx_n   = '0;
          end else begin
            state_n = ST_PLAY_ON;
            idx_n   = idx + 1'b1;
          end
        end
      end
      ST_WAIT_KEY: begin
        if (key_valid) begin
          state_n = ST_ECHO;
          miss_n  = !key_match;
        end
      end
      ST_ECHO: begin
        if (last_tick) begin
          if (match_reg) begin
            if (idx != cur_level - 1'b1) begin
              state_n = ST_WAIT_KEY;
              idx_n   = idx + 1'b1;
            end else if (cur_level != LVL_W'(MAX_LEN)) begin
              state_n = ST_PLAY_ON;
              idx_n   = '0;
              level_n = cur_level + 1'b1;
            end else begin
              state_n = ST_DONE;
            end
          end else begin
`ifdef GAME_LIVES_EN
            if (miss_cnt == MISS_W'(LIVES - 1)) begin
              state_n = ST_DONE;
            end else begin
              miss_cnt_n = miss_cnt + 1'b1;
              state_n    = ST_PLAY_ON;
              idx_n      = '0;
            end
`else
            state_n = ST_PLAY_ON;
            idx_n   = '0;
`endif
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      loaded    <= 1'b0;
      idx       <= '0;
      cur_level <= LVL_W'(1);
      tick_cnt  <= '0;
      miss_out  <= 1'b0;
`ifdef GAME_LIVES_EN
      miss_cnt  <= '0;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      cur_level <= level_n;
      miss_out  <= miss_n;
      tick_cnt  <= restart ? '0 : (tick ? tick_cnt + 1'b1 : tick_cnt);
      if (seq_load && idle_like) loaded <= 1'b1;
`ifdef GAME_LIVES_EN
      miss_cnt  <= miss_cnt_n;
`endif
    end
  end

  // Sequence and key capture registers hold data only; outputs never expose them outside their states.
  always_ff @(posedge clk) begin
    if (seq_load && idle_like) seq_reg <= seq_data;
    if ((state == ST_WAIT_KEY) && key_valid) begin
      key_reg   <= key_code;
      match_reg <= key_match;
    end
  end

  always_comb begin
    piezo_out = CODE_W'(SILENT);
    if (state == ST_PLAY_ON)  piezo_out = note_code;
    else if (state == ST_ECHO) piezo_out = key_reg;
  end

  assign led_out  = piezo_out;
  assign busy     = (state == ST_PLAY_ON) || (state == ST_PLAY_OFF);
  assign game_end = (state == ST_DONE);
  assign level    = (state == ST_IDLE) ? '0 : cur_level;

endmodule

// File: tb/tb_melody_game_engine.sv
// Bench for melody_game_engine: queue-based reference model, per-cycle compare, directed and random stimulus.
`timescale 1ns/1ps
module tb_melody_game_engine;

  localparam int MAX_LEN = 8, NOTE_W = 3, TICK_DIV = 4;
  localparam int ON_TICKS = 3, OFF_TICKS = 1, ECHO_TICKS = 2, LIVES = 3;
  localparam int LVL_W = $clog2(MAX_LEN + 1);
  localparam int SEQ_W = MAX_LEN * NOTE_W;
  localparam int K_IDLE = 0, K_PLAY = 1, K_WAIT = 2, K_ECHO = 3, K_DONE = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [SEQ_W-1:0]  seq_data = '0;
  logic              seq_load = 1'b0, start = 1'b0, key_valid = 1'b0;
  logic [NOTE_W:0]   key_code = '0;
  logic [NOTE_W:0]   piezo_out, led_out;
  logic              miss_out, game_end, busy;
  logic [LVL_W-1:0]  level;

  int checks = 0;
  int failures = 0;

  melody_game_engine #(
    .MAX_LEN(MAX_LEN), .NOTE_W(NOTE_W), .TICK_DIV(TICK_DIV),
    .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .ECHO_TICKS(ECHO_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .seq_data(seq_data), .seq_load(seq_load), .start(start),
    .key_valid(key_valid), .key_code(key_code), .piezo_out(piezo_out), .led_out(led_out),
    .miss_out(miss_out), .game_end(game_end), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  // Reference model: expected piezo values per cycle are queued for each timed phase.
  int  m_kind, m_level, m_pos, m_misses, ep;
  bit  m_loaded, m_was_loaded, m_ok, m_miss, chk_en = 1'b0;
  int  m_seq[MAX_LEN];
  int  q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void fill_playback();
    q.delete();
    for (int i = 0; i < m_level; i++) begin
      repeat (ON_TICKS * TICK_DIV) q.push_back(m_seq[i] + 1);
      repeat (OFF_TICKS * TICK_DIV) q.push_back(0);
    end
    m_kind = K_PLAY;
    m_pos  = 0;
  endfunction

  function automatic void resolve();
    if (m_ok) begin
      if (m_pos < m_level - 1) begin
        m_pos++;
        m_kind = K_WAIT;
      end else if (m_level < MAX_LEN) begin
        m_level++;
        fill_playback();
      end else begin
        m_kind = K_DONE;
      end
    end else begin
`ifdef GAME_LIVES_EN
      if (m_misses == LIVES - 1) begin
        m_kind = K_DONE;
      end else begin
        m_misses++;
        fill_playback();
      end
`else
      fill_playback();
`endif
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_kind = K_IDLE; m_loaded = 0; m_level = 1; m_pos = 0; m_misses = 0; m_miss = 0;
      q.delete();
    end else begin
      m_miss = 0;
      case (m_kind)
        K_IDLE, K_DONE: begin
          m_was_loaded = m_loaded;
          if (seq_load) begin
            for (int i = 0; i < MAX_LEN; i++) m_seq[i] = int'(seq_data[i*NOTE_W +: NOTE_W]);
            m_loaded = 1;
          end
          if (start && m_was_loaded) begin
            m_level = 1;
            m_misses = 0;
            fill_playback();
          end
        end
        K_PLAY: begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            m_kind = K_WAIT;
            m_pos = 0;
          end
        end
        K_WAIT: begin
          if (key_valid) begin
            m_ok   = (int'(key_code) == m_seq[m_pos] + 1);
            m_miss = !m_ok;
            q.delete();
            repeat (ECHO_TICKS * TICK_DIV) q.push_back(int'(key_code));
            m_kind = K_ECHO;
          end
        end
        default: begin
          void'(q.pop_front());
          if (q.size() == 0) resolve();
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      ep = ((m_kind == K_PLAY) || (m_kind == K_ECHO)) ? q[0] : 0;
      check("piezo", int'(piezo_out), ep);
      check("led", int'(led_out), ep);
      check("busy", int'(busy), int'(m_kind == K_PLAY));
      check("game_end", int'(game_end), int'(m_kind == K_DONE));
      check("level", int'(level), (m_kind == K_IDLE) ? 0 : m_level);
      check("miss_out", int'(miss_out), int'(m_miss));
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load(input logic [SEQ_W-1:0] d);
    seq_data = d;
    seq_load = 1'b1;
    @(posedge clk); #1;
    seq_load = 1'b0;
  endtask

  task automatic wait_kind(input int k, input string what);
    int n;
    n = 0;
    while ((m_kind != k) && (n < 3000)) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_kind != k) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual_state=%0d required_state=%0d", what, m_kind, k);
    end
  endtask

  task automatic press(input int code);
    wait_kind(K_WAIT, "wait_key");
    key_code  = (NOTE_W+1)'(code);
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  logic [SEQ_W-1:0] seq_incr;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MAX_LEN; i++) seq_incr[i*NOTE_W +: NOTE_W] = NOTE_W'(i);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_piezo", int'(piezo_out), 0);
    check("rst_level", int'(level), 0);

    // start without a loaded sequence does nothing
    pulse_start();
    repeat (3) @(negedge clk);
    check("noload_busy", int'(busy), 0);
    check("noload_level", int'(level), 0);

    // asynchronous reset in the middle of a note
    @(posedge clk); #1;
    load(seq_incr);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    check("arst_piezo", int'(piezo_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_game_end", int'(game_end), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // first playback: 12 clocks of tone 1, 4 of silence
    load(seq_incr);
    pulse_start();
    @(negedge clk);
    check("lvl1_first_piezo", int'(piezo_out), 1);
    check("lvl1_first_busy", int'(busy), 1);
    repeat (11) @(negedge clk);
    check("lvl1_on_last", int'(piezo_out), 1);
    @(negedge clk);
    check("lvl1_off_first", int'(piezo_out), 0);
    check("lvl1_off_busy", int'(busy), 1);
    repeat (4) @(negedge clk);
    check("lvl1_wait_busy", int'(busy), 0);
    check("lvl1_wait_level", int'(level), 1);

    press(1);
    @(negedge clk);
    check("echo_first", int'(piezo_out), 1);
    repeat (7) @(negedge clk);
    check("echo_last", int'(piezo_out), 1);
    check("echo_busy", int'(busy), 0);
    @(negedge clk);
    check("lvl2_play_piezo", int'(piezo_out), 1);
    check("lvl2_level", int'(level), 2);

    // wrong second key at level 2
    press(1);
    press(5);
    @(negedge clk);
    check("miss_pulse", int'(miss_out), 1);
    check("miss_echo", int'(piezo_out), 5);
    @(negedge clk);
    check("miss_pulse_end", int'(miss_out), 0);
    repeat (7) @(negedge clk);
    check("replay_level", int'(level), 2);
    check("replay_piezo", int'(piezo_out), 1);
    check("replay_busy", int'(busy), 1);

    press(1);
    press(2);
    repeat (9) @(negedge clk);
    check("lvl3_level", int'(level), 3);
    check("lvl3_note0", int'(piezo_out), 1);
    repeat (16) @(negedge clk);
    check("lvl3_note1", int'(piezo_out), 2);
    repeat (16) @(negedge clk);
    check("lvl3_note2", int'(piezo_out), 3);

    for (int l = 3; l <= MAX_LEN; l++)
      for (int i = 0; i < l; i++) press(i + 1);
    wait_kind(K_DONE, "win");
    @(negedge clk);
    check("win_game_end", int'(game_end), 1);
    check("win_piezo", int'(piezo_out), 0);
    check("win_level", int'(level), MAX_LEN);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("restart_game_end", int'(game_end), 0);
    check("restart_level", int'(level), 1);

`ifdef GAME_LIVES_EN
    press(3);
    repeat (10) @(posedge clk);
    #1;
    key_code = 4'd3; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    press(0);
    press(7);
    repeat (9) @(negedge clk);
    check("lives_game_end", int'(game_end), 1);
    @(posedge clk); #1;
    pulse_start();
`endif

    // randomized play
    for (int c = 0; c < 6000; c++) begin
      seq_load = 1'b0; start = 1'b0; key_valid = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        seq_data = SEQ_W'($urandom);
        seq_load = 1'b1;
      end
      if ($urandom_range(0, 59) == 0) start = 1'b1;
      if ((m_kind == K_WAIT) && ($urandom_range(0, 4) == 0)) begin
        key_valid = 1'b1;
        key_code  = ($urandom_range(0, 9) == 0) ? (NOTE_W+1)'($urandom_range(0, 15))
                                               : (NOTE_W+1)'(m_seq[m_pos] + 1);
      end else if ($urandom_range(0, 29) == 0) begin
        key_valid = 1'b1;
        key_code  = (NOTE_W+1)'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
    end
    seq_load = 1'b0; start = 1'b0; key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
